// File: rtl/bus_master_port.sv
// ---------------------------------------------------------------------------
// bus_master_port
//   Initiator end of the single-bit serial bus served by the BRAM slave.
//   It takes one parallel read or write request at a time. It sends a
//   header cycle and then the address MSB-first on the bus. For a write,
//   the write data is sent MSB-first on DataOut, aligned to the last N
//   address bits. For a read, it collects the serial read data from the
//   slave. Each accepted request ends with exactly one rsp_valid pulse.
//
//   Ports
//     clk, rst                 clock; asynchronous active-high reset
//     req_valid/req_ready      request handshake (req_ready is combinational)
//     req_wren, req_addr,      request: direction, address, write data
//     req_wdata
//     rsp_valid, rsp_rdata,    one-cycle response pulse, read data, timeout
//     rsp_err                  error flag
//     validOut, wren,          serial bus outputs to the slave (registered)
//     Address, DataOut
//     ready, validIn, DataIn   serial bus inputs from the slave
// ---------------------------------------------------------------------------
module bus_master_port #(
   parameter int N       = 8,
   parameter int ADN     = 12,
   parameter int TURN    = 2,
   parameter int TIMEOUT = 64
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           req_valid,
   output logic           req_ready,
   input  logic           req_wren,
   input  logic [ADN-1:0] req_addr,
   input  logic [N-1:0]   req_wdata,
   output logic           rsp_valid,
   output logic [N-1:0]   rsp_rdata,
   output logic           rsp_err,
   output logic           validOut,
   output logic           wren,
   output logic           Address,
   output logic           DataOut,
   input  logic           ready,
   input  logic           validIn,
   input  logic           DataIn
);

   localparam int AW = (ADN > 1) ? $clog2(ADN) : 1;
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam int DW = $clog2(N + 1);
   localparam int UW = $clog2(TURN + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_HDR,
      S_ADDR,
      S_RWAIT,
      S_RDATA,
      S_TURN
   } state_t;

   state_t          r_state;
   logic [ADN-1:0]  r_ash;     // address shift register, MSB is the next bit out
   logic [ADN-1:0]  r_dsh;     // write data zero-padded to ADN bits, so it lines up with the address tail
   logic [N-2:0]    r_shift;   // read data collected so far; the newest bit completes the word
   logic [AW-1:0]   r_acnt;    // address bit index on the bus
   logic [TW-1:0]   r_tcnt;    // cycles spent in RWAIT/RDATA
   logic [DW-1:0]   r_dcnt;    // read data bits received
   logic [UW-1:0]   r_ucnt;    // turnaround cycles elapsed
   logic            w_req_ready;
   logic [N-1:0]    w_rd_next;
   logic            w_tmo;

   always_comb begin
      w_req_ready = (r_state == S_IDLE) & ready & ~rst;
      w_rd_next   = {r_shift, DataIn};
      w_tmo       = (r_tcnt == TW'(TIMEOUT - 1));
   end

   assign req_ready = w_req_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_ash     <= '0;
         r_dsh     <= '0;
         r_shift   <= '0;
         r_acnt    <= '0;
         r_tcnt    <= '0;
         r_dcnt    <= '0;
         r_ucnt    <= '0;
         validOut  <= 1'b0;
         wren      <= 1'b0;
         Address   <= 1'b0;
         DataOut   <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_err   <= 1'b0;
         rsp_rdata <= '0;
      end else begin
         rsp_valid <= 1'b0;
         rsp_err   <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (req_valid && w_req_ready) begin
                  r_ash    <= req_addr;
                  r_dsh    <= req_wren ? ADN'(req_wdata) : '0;
                  wren     <= req_wren;
                  validOut <= 1'b1;
                  Address  <= 1'b0;
                  DataOut  <= 1'b0;
                  r_state  <= S_HDR;
               end
            end

            // The bus outputs are registered, so each edge loads the bit for
            // the next cycle. Leaving HDR puts address bit 0 on the bus.
            S_HDR: begin
               Address <= r_ash[ADN-1];
               DataOut <= r_dsh[ADN-1];
               r_ash   <= r_ash << 1;
               r_dsh   <= r_dsh << 1;
               r_acnt  <= '0;
               r_state <= S_ADDR;
            end

            S_ADDR: begin
               if (r_acnt == AW'(ADN - 1)) begin
                  validOut <= 1'b0;
                  Address  <= 1'b0;
                  DataOut  <= 1'b0;
                  r_tcnt   <= '0;
                  r_dcnt   <= '0;
                  r_ucnt   <= '0;
                  if (wren) begin
                     rsp_valid <= 1'b1;
                     rsp_rdata <= '0;
                     r_state   <= S_TURN;
                  end else begin
                     r_state   <= S_RWAIT;
                  end
               end else begin
                  Address <= r_ash[ADN-1];
                  DataOut <= r_dsh[ADN-1];
                  r_ash   <= r_ash << 1;
                  r_dsh   <= r_dsh << 1;
                  r_acnt  <= r_acnt + 1'b1;
               end
            end

            // The first validIn beat is the slave preamble and carries no data.
            S_RWAIT: begin
               if (w_tmo) begin
                  rsp_valid <= 1'b1;
                  rsp_err   <= 1'b1;
                  rsp_rdata <= '0;
                  r_state   <= S_TURN;
               end else begin
                  r_tcnt <= r_tcnt + 1'b1;
                  if (validIn) begin
                     r_state <= S_RDATA;
                  end
               end
            end

            // If the last data bit arrives in the same cycle as the timeout,
            // the data wins.
            S_RDATA: begin
               if (validIn && (r_dcnt == DW'(N - 1))) begin
                  rsp_valid <= 1'b1;
                  rsp_rdata <= w_rd_next;
                  r_state   <= S_TURN;
               end else if (w_tmo) begin
                  rsp_valid <= 1'b1;
                  rsp_err   <= 1'b1;
                  rsp_rdata <= '0;
                  r_state   <= S_TURN;
               end else begin
                  r_tcnt <= r_tcnt + 1'b1;
                  if (validIn) begin
                     r_shift <= w_rd_next[N-2:0];
                     r_dcnt  <= r_dcnt + 1'b1;
                  end
               end
            end

            S_TURN: begin
               if (r_ucnt == UW'(TURN - 1)) begin
                  wren    <= 1'b0;
                  r_state <= S_IDLE;
               end else begin
                  r_ucnt <= r_ucnt + 1'b1;
               end
            end

            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bus_master_port.sv
module tb_bus_master_port;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic        req_wren;
   logic [11:0] req_addr;
   logic [7:0]  req_wdata;
   logic        rsp_valid;
   logic [7:0]  rsp_rdata;
   logic        rsp_err;
   logic        validOut;
   logic        wren;
   logic        Address;
   logic        DataOut;
   logic        ready;
   logic        validIn;
   logic        DataIn;

   int total = 0;
   int bad   = 0;
   int cnt;

   // Memory of the slave model. A write fills it from the observed bus
   // bits. A read sends its contents back.
   logic [7:0] mem [4096];

   bus_master_port #(
      .N(8),
      .ADN(12),
      .TURN(2),
      .TIMEOUT(64)
   ) dut (
      .clk(clk),
      .rst(rst),
      .req_valid(req_valid),
      .req_ready(req_ready),
      .req_wren(req_wren),
      .req_addr(req_addr),
      .req_wdata(req_wdata),
      .rsp_valid(rsp_valid),
      .rsp_rdata(rsp_rdata),
      .rsp_err(rsp_err),
      .validOut(validOut),
      .wren(wren),
      .Address(Address),
      .DataOut(DataOut),
      .ready(ready),
      .validIn(validIn),
      .DataIn(DataIn)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Full write. Entered in an idle cycle just after an edge.
   task automatic do_write(input logic [11:0] a, input logic [7:0] d);
      logic [11:0] pad;
      logic [11:0] cap_a;
      logic [11:0] cap_d;
      pad = {4'h0, d};
      cap_a = '0;
      cap_d = '0;
      req_valid = 1'b1; req_wren = 1'b1; req_addr = a; req_wdata = d;
      chk("wr_req_ready_idle", 32'(req_ready), 32'd1);
      step();                                  // T1
      req_valid = 1'b0;
      chk("wr_hdr", 32'({validOut, wren, Address, DataOut, req_ready}), 32'b11000);
      for (int i = 0; i < 12; i++) begin
         step();                               // T2+i
         chk("wr_addr_bit", 32'({validOut, wren, Address, DataOut, rsp_valid}),
             32'({1'b1, 1'b1, a[11-i], pad[11-i], 1'b0}));
         cap_a = {cap_a[10:0], Address};
         cap_d = {cap_d[10:0], DataOut};
      end
      mem[cap_a] = cap_d[7:0];
      step();                                  // T14
      chk("wr_rsp", 32'({rsp_valid, rsp_err, rsp_rdata}), 32'({1'b1, 1'b0, 8'h00}));
      chk("wr_turn1_bus", 32'({validOut, wren, Address, DataOut, req_ready}), 32'b01000);
      step();                                  // T15
      chk("wr_turn2", 32'({rsp_valid, wren, req_ready}), 32'b010);
      step();                                  // T16, IDLE
      chk("wr_idle", 32'({req_ready, wren, validOut}), 32'b100);
      chk("wr_slave_mem", 32'(mem[a]), 32'(d));
   endtask

   // Full read with slave preamble. Optionally, 3 idle cycles are placed
   // between data bits.
   task automatic do_read(input logic [11:0] a, input bit gaps, input logic [7:0] exp_d);
      logic [7:0] sd;
      int early;
      sd = mem[a];
      early = 0;
      req_valid = 1'b1; req_wren = 1'b0; req_addr = a; req_wdata = 8'hFF;
      chk("rd_req_ready_idle", 32'(req_ready), 32'd1);
      step();                                  // T1
      req_valid = 1'b0;
      chk("rd_hdr", 32'({validOut, wren, Address, DataOut}), 32'b1000);
      for (int i = 0; i < 12; i++) begin
         step();
         chk("rd_addr_bit", 32'({validOut, wren, Address, DataOut}),
             32'({1'b1, 1'b0, a[11-i], 1'b0}));
      end
      step();                                  // T14, first RWAIT cycle
      chk("rd_rwait_bus", 32'({validOut, Address, DataOut, rsp_valid}), 32'b0000);
      validIn = 1'b1; DataIn = 1'b1;           // preamble, must be discarded
      step();
      for (int k = 0; k < 8; k++) begin
         if (gaps && k > 0) begin
            validIn = 1'b0; DataIn = 1'b1;
            repeat (3) begin
               step();
               if (rsp_valid) early++;
            end
         end
         validIn = 1'b1; DataIn = sd[7-k];
         step();
         if (k < 7 && rsp_valid) early++;
      end
      validIn = 1'b0; DataIn = 1'b0;
      chk("rd_no_early_rsp", 32'(early), 32'd0);
      chk("rd_rsp", 32'({rsp_valid, rsp_err, rsp_rdata}), 32'({1'b1, 1'b0, exp_d}));
      step();
      chk("rd_rsp_pulse", 32'({rsp_valid, req_ready}), 32'b00);
      step();
      chk("rd_idle", 32'({req_ready, wren}), 32'b10);
   endtask

   initial begin
      rst = 1'b1; req_valid = 1'b0; req_wren = 1'b0; req_addr = '0; req_wdata = '0;
      ready = 1'b1; validIn = 1'b0; DataIn = 1'b0;
      repeat (2) step();
      chk("reset_outputs", 32'({validOut, wren, Address, DataOut, rsp_valid, rsp_err, rsp_rdata}), 32'd0);
      chk("reset_req_ready", 32'(req_ready), 32'd0);
      rst = 1'b0;
      #1;
      chk("post_reset_ready", 32'(req_ready), 32'd1);
      step();

      // Write, then read back the same word through the slave.
      do_write(12'hA5C, 8'h3E);
      do_read(12'hA5C, 1'b0, 8'h3E);

      // Silent slave: the timeout fires exactly 64 cycles after RWAIT is entered.
      req_valid = 1'b1; req_wren = 1'b0; req_addr = 12'h123;
      step();                                  // T1
      req_valid = 1'b0;
      repeat (13) step();                      // T14
      chk("tmo_rwait_entry", 32'({rsp_valid, validOut}), 32'b00);
      cnt = 0;
      repeat (63) begin
         step();
         if (rsp_valid) cnt++;
      end
      chk("tmo_no_early", 32'(cnt), 32'd0);
      step();                                  // T14+64
      chk("tmo_rsp", 32'({rsp_valid, rsp_err, rsp_rdata}), 32'({1'b1, 1'b1, 8'h00}));
      validIn = 1'b1; DataIn = 1'b1;           // late bits, ignored
      step();
      chk("tmo_late_ignored", 32'({rsp_valid, rsp_err}), 32'b00);
      step();
      validIn = 1'b0; DataIn = 1'b0;
      chk("tmo_idle", 32'({rsp_valid, req_ready}), 32'b01);

      // Read with gaps between the data bits.
      do_read(12'hA5C, 1'b1, 8'h3E);

      // Reset during address bit 5 of a write.
      req_valid = 1'b1; req_wren = 1'b1; req_addr = 12'h3C1; req_wdata = 8'hA7;
      step();                                  // T1
      req_valid = 1'b0;
      repeat (6) step();                       // T7, address bit 5
      chk("rst_mid_before", 32'({validOut, wren, Address, DataOut}), 32'b1110);
      rst = 1'b1;
      #1;
      chk("rst_mid_outputs", 32'({validOut, wren, Address, DataOut, rsp_valid, rsp_err}), 32'd0);
      chk("rst_mid_req_ready", 32'(req_ready), 32'd0);
      step();
      rst = 1'b0;
      cnt = 0;
      repeat (20) begin
         step();
         if (rsp_valid || validOut) cnt++;
      end
      chk("rst_no_rsp", 32'(cnt), 32'd0);
      do_write(12'h5A3, 8'hC9);
      do_read(12'h5A3, 1'b0, 8'hC9);

      // Back-to-back requests with req_valid held, and the slave ready gating req_ready.
      req_valid = 1'b1; req_wren = 1'b1; req_addr = 12'h111; req_wdata = 8'h22;
      step();                                  // T1
      cnt = 0;
      for (int c = 1; c <= 15; c++) begin
         if (req_ready) cnt++;
         step();
      end                                      // T16
      chk("b2b_busy_ready_low", 32'(cnt), 32'd0);
      chk("b2b_ready_after_turn", 32'(req_ready), 32'd1);
      ready = 1'b0;
      #1;
      chk("b2b_slave_not_ready", 32'(req_ready), 32'd0);
      step();
      chk("b2b_not_accepted", 32'(validOut), 32'd0);
      ready = 1'b1;
      #1;
      chk("b2b_ready_again", 32'(req_ready), 32'd1);
      step();
      req_valid = 1'b0;
      chk("b2b_second_accepted", 32'({validOut, wren}), 32'b11);
      cnt = 0;
      repeat (20) begin
         step();
         if (rsp_valid) cnt++;
      end
      chk("b2b_one_rsp", 32'(cnt), 32'd1);
      chk("b2b_final_idle", 32'(req_ready), 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
